// File: rtl/la132_sram_arbiter_if.sv
// One la132 SRAM request port. The requester (master) drives the request fields;
// the arbiter (slave) answers with ack and a one-cycle-later completion.
interface la132_sram_arbiter_if;
  logic        en;
  logic        wr;
  logic [3:0]  strb;
  logic        fetch;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        rrdy;
  logic        resp;
  logic [31:0] rdata;

  modport master (
    output en, wr, strb, fetch, addr, wdata,
    input  ack, rrdy, resp, rdata
  );

  modport slave (
    input  en, wr, strb, fetch, addr, wdata,
    output ack, rrdy, resp, rdata
  );
endinterface

// File: rtl/la132_sram_arbiter.sv
// Round-robin sharing of one single-port SRAM between the la132 instruction and
// data request ports, with address-window checking and a one-cycle response stage.
module la132_sram_arbiter #(
  parameter logic [31:0] ADDR_BASE = 32'h1C00_0000,
  parameter int unsigned AW        = 13
) (
  input  logic                       clk,
  input  logic                       hard_resetn,
  la132_sram_arbiter_if.slave        inst_sram,
  la132_sram_arbiter_if.slave        data_sram,
  output logic                       mem_en,
  output logic                       mem_wr,
  output logic [3:0]                 mem_strb,
  output logic                       mem_fetch,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [32:0] WIN_BYTES = 33'd4 << AW;

  owner_e      last_grant;
  logic        rsp_valid;
  owner_e      rsp_owner;
  logic        rsp_err;
  logic        rsp_wr;

  logic        grant_valid;
  owner_e      grant_owner;
  logic        sel_wr;
  logic        sel_fetch;
  logic [3:0]  sel_strb;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] offset;
  logic        hit;
  logic [31:0] rsp_data;

  // Ties go to whichever port did not win the previous grant.
  always_comb begin
    grant_valid = hard_resetn && (inst_sram.en || data_sram.en);
    grant_owner = OWNER_INST;
    if (data_sram.en && (!inst_sram.en || last_grant == OWNER_INST)) begin
      grant_owner = OWNER_DATA;
    end
  end

  always_comb begin
    if (grant_owner == OWNER_DATA) begin
      sel_wr    = data_sram.wr;
      sel_fetch = data_sram.fetch;
      sel_strb  = data_sram.strb;
      sel_addr  = data_sram.addr;
      sel_wdata = data_sram.wdata;
    end else begin
      sel_wr    = inst_sram.wr;
      sel_fetch = inst_sram.fetch;
      sel_strb  = inst_sram.strb;
      sel_addr  = inst_sram.addr;
      sel_wdata = inst_sram.wdata;
    end
  end

  // Unsigned subtraction makes addresses below the base wrap to large offsets and miss.
  always_comb begin
    offset = sel_addr - ADDR_BASE;
    hit    = grant_valid && ({1'b0, offset} < WIN_BYTES);
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_strb  = '0;
    mem_fetch = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (hit) begin
      mem_en    = 1'b1;
      mem_wr    = sel_wr;
      mem_strb  = sel_strb;
      mem_fetch = sel_fetch;
      mem_addr  = offset[AW+1:2];
      mem_wdata = sel_wdata;
    end
  end

  always_comb begin
    inst_sram.ack = grant_valid && (grant_owner == OWNER_INST);
    data_sram.ack = grant_valid && (grant_owner == OWNER_DATA);
  end

  always_ff @(posedge clk or negedge hard_resetn) begin
    if (!hard_resetn) begin
      last_grant <= OWNER_INST;
      rsp_valid  <= 1'b0;
      rsp_owner  <= OWNER_INST;
      rsp_err    <= 1'b0;
      rsp_wr     <= 1'b0;
    end else begin
      rsp_valid <= grant_valid;
      if (grant_valid) begin
        last_grant <= grant_owner;
        rsp_owner  <= grant_owner;
        rsp_err    <= !hit;
        rsp_wr     <= sel_wr;
      end
    end
  end

  // Only a successful read returns SRAM data; writes and errors complete with zero.
  always_comb begin
    rsp_data = (rsp_valid && !rsp_err && !rsp_wr) ? mem_rdata : 32'h0;

    inst_sram.rrdy  = rsp_valid && (rsp_owner == OWNER_INST);
    inst_sram.resp  = inst_sram.rrdy && rsp_err;
    inst_sram.rdata = inst_sram.rrdy ? rsp_data : 32'h0;

    data_sram.rrdy  = rsp_valid && (rsp_owner == OWNER_DATA);
    data_sram.resp  = data_sram.rrdy && rsp_err;
    data_sram.rdata = data_sram.rrdy ? rsp_data : 32'h0;
  end

endmodule

// File: tb/tb_la132_sram_arbiter.sv
// Randomized and directed bench for la132_sram_arbiter against a cycle-level
// reference model (round-robin rule, window check, pending-response scoreboard).
module tb_la132_sram_arbiter;

  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam int          AW    = 13;
  localparam int          WORDS = 1 << AW;
  localparam logic [31:0] WIN   = 32'(4 * WORDS);

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [3:0]  strb;
    logic        fetch;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          valid;
    bit          to_data;
    bit          err;
    logic [31:0] rdata;
  } rsp_t;

  logic          clk = 1'b0;
  logic          hard_resetn;
  logic          mem_en;
  logic          mem_wr;
  logic [3:0]    mem_strb;
  logic          mem_fetch;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  la132_sram_arbiter_if inst_sram ();
  la132_sram_arbiter_if data_sram ();

  la132_sram_arbiter #(
    .ADDR_BASE (BASE),
    .AW        (AW)
  ) dut (
    .clk         (clk),
    .hard_resetn (hard_resetn),
    .inst_sram   (inst_sram),
    .data_sram   (data_sram),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_strb    (mem_strb),
    .mem_fetch   (mem_fetch),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM device model driven by the DUT's mem_* bus.
  logic [31:0] sram [WORDS];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_strb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  logic [31:0] ref_mem [WORDS];
  bit          last_was_data;
  rsp_t        pending;
  int          errors;
  int          checks;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_output({tag, "_inst_ack"},   inst_sram.ack,   0);
    check_output({tag, "_data_ack"},   data_sram.ack,   0);
    check_output({tag, "_inst_rrdy"},  inst_sram.rrdy,  0);
    check_output({tag, "_data_rrdy"},  data_sram.rrdy,  0);
    check_output({tag, "_inst_resp"},  inst_sram.resp,  0);
    check_output({tag, "_data_resp"},  data_sram.resp,  0);
    check_output({tag, "_inst_rdata"}, inst_sram.rdata, 0);
    check_output({tag, "_data_rdata"}, data_sram.rdata, 0);
    check_output({tag, "_mem_en"},     mem_en,          0);
    check_output({tag, "_mem_wr"},     mem_wr,          0);
    check_output({tag, "_mem_strb"},   mem_strb,        0);
    check_output({tag, "_mem_fetch"},  mem_fetch,       0);
    check_output({tag, "_mem_addr"},   mem_addr,        0);
    check_output({tag, "_mem_wdata"},  mem_wdata,       0);
  endtask

  function automatic req_t idle_req();
    req_t r;
    r.en    = 1'b0;
    r.wr    = 1'($urandom_range(0, 1));
    r.strb  = 4'($urandom);
    r.fetch = 1'($urandom_range(0, 1));
    r.addr  = BASE + $urandom_range(0, 64);
    r.wdata = $urandom;
    return r;
  endfunction

  function automatic req_t make_req(input bit wr, input logic [31:0] addr,
                                    input logic [3:0] strb, input logic [31:0] wdata);
    req_t r;
    r.en    = 1'b1;
    r.wr    = wr;
    r.strb  = strb;
    r.fetch = 1'($urandom_range(0, 1));
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = BASE - 4 * $urandom_range(1, 4);
      2:       a = BASE + WIN + $urandom_range(0, 7);
      default: a = BASE + $urandom_range(0, WIN - 1);
    endcase
    return make_req(1'($urandom_range(0, 1)), a, 4'($urandom), $urandom);
  endfunction

  // One clock cycle: drive both ports, compare against the model, advance the model.
  task automatic apply_stimulus(input req_t ri, input req_t rd, output bit gi, output bit gd);
    req_t        w;
    logic [31:0] off;
    bit          hit;
    rsp_t        nxt;
    @(negedge clk);
    inst_sram.en    = ri.en;    data_sram.en    = rd.en;
    inst_sram.wr    = ri.wr;    data_sram.wr    = rd.wr;
    inst_sram.strb  = ri.strb;  data_sram.strb  = rd.strb;
    inst_sram.fetch = ri.fetch; data_sram.fetch = rd.fetch;
    inst_sram.addr  = ri.addr;  data_sram.addr  = rd.addr;
    inst_sram.wdata = ri.wdata; data_sram.wdata = rd.wdata;
    #1;
    if (ri.en && rd.en) begin
      gd = !last_was_data;
      gi = last_was_data;
    end else begin
      gi = ri.en;
      gd = rd.en;
    end
    w   = gd ? rd : ri;
    off = w.addr - BASE;
    hit = (gi || gd) && (off < WIN);

    check_output("inst_ack",  inst_sram.ack, gi);
    check_output("data_ack",  data_sram.ack, gd);
    check_output("mem_en",    mem_en,    hit);
    check_output("mem_wr",    mem_wr,    hit ? w.wr : 1'b0);
    check_output("mem_strb",  mem_strb,  hit ? w.strb : 4'h0);
    check_output("mem_fetch", mem_fetch, hit ? w.fetch : 1'b0);
    check_output("mem_addr",  mem_addr,  hit ? off / 4 : 32'h0);
    check_output("mem_wdata", mem_wdata, hit ? w.wdata : 32'h0);

    check_output("inst_rrdy",  inst_sram.rrdy,  pending.valid && !pending.to_data);
    check_output("data_rrdy",  data_sram.rrdy,  pending.valid &&  pending.to_data);
    check_output("inst_resp",  inst_sram.resp,  pending.valid && !pending.to_data && pending.err);
    check_output("data_resp",  data_sram.resp,  pending.valid &&  pending.to_data && pending.err);
    check_output("inst_rdata", inst_sram.rdata, (pending.valid && !pending.to_data) ? pending.rdata : 32'h0);
    check_output("data_rdata", data_sram.rdata, (pending.valid &&  pending.to_data) ? pending.rdata : 32'h0);

    nxt.valid   = gi || gd;
    nxt.to_data = gd;
    nxt.err     = !hit;
    nxt.rdata   = 32'h0;
    if (gi || gd) last_was_data = gd;
    if (hit) begin
      if (w.wr) begin
        for (int b = 0; b < 4; b++) begin
          if (w.strb[b]) ref_mem[off / 4][8*b +: 8] = w.wdata[8*b +: 8];
        end
      end else begin
        nxt.rdata = ref_mem[off / 4];
      end
    end
    pending = nxt;
  endtask

  task automatic drive_idle();
    inst_sram.en = 1'b0;
    data_sram.en = 1'b0;
  endtask

  initial begin
    bit   gi, gd;
    req_t ci, cd;
    errors = 0;
    checks = 0;
    last_was_data = 1'b0;
    pending.valid = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      sram[i]    = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
      ref_mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0000;
    end
    sram[4]    = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    // Reset: outputs stay quiet even with both requests raised.
    hard_resetn = 1'b0;
    ci = make_req(1'b0, BASE, 4'hF, 32'h0);
    inst_sram.en = 1'b1; inst_sram.wr = 1'b0; inst_sram.strb = 4'hF; inst_sram.fetch = 1'b1;
    inst_sram.addr = BASE; inst_sram.wdata = 32'h0;
    data_sram.en = 1'b1; data_sram.wr = 1'b1; data_sram.strb = 4'hF; data_sram.fetch = 1'b1;
    data_sram.addr = BASE + 8; data_sram.wdata = 32'hFFFF_FFFF;
    #12;
    check_quiet("reset");
    drive_idle();
    @(negedge clk);
    #2 hard_resetn = 1'b1;

    // Contention from reset: data, inst, data, inst.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(make_req(1'b0, BASE + 32'(4 * k), 4'h0, 32'h0),
                     make_req(1'b0, BASE + 32'(64 + 4 * k), 4'h0, 32'h0), gi, gd);
    end
    apply_stimulus(idle_req(), idle_req(), gi, gd);

    // Single read, write, out-of-range reads, then back-to-back reads.
    apply_stimulus(make_req(1'b0, 32'h1C00_0010, 4'h0, 32'h0), idle_req(), gi, gd);
    apply_stimulus(idle_req(), idle_req(), gi, gd);
    apply_stimulus(idle_req(), make_req(1'b1, 32'h1C00_0004, 4'b0011, 32'h1234_5678), gi, gd);
    apply_stimulus(idle_req(), make_req(1'b0, 32'h1BFF_FFFC, 4'h0, 32'h0), gi, gd);
    apply_stimulus(idle_req(), make_req(1'b0, 32'h1C00_8000, 4'h0, 32'h0), gi, gd);
    apply_stimulus(idle_req(), idle_req(), gi, gd);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(make_req(1'b0, BASE + 32'(4 * k), 4'h0, 32'h0), idle_req(), gi, gd);
    end
    apply_stimulus(idle_req(), idle_req(), gi, gd);

    // Reset in the cycle after an ack drops the pending completion.
    apply_stimulus(make_req(1'b0, BASE + 32'h20, 4'h0, 32'h0), idle_req(), gi, gd);
    @(posedge clk);
    #2 hard_resetn = 1'b0;
    #1 check_quiet("midrst");
    drive_idle();
    @(negedge clk);
    #1 check_quiet("midrst_hold");
    #1 hard_resetn = 1'b1;
    pending.valid = 1'b0;
    last_was_data = 1'b0;
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(make_req(1'b0, BASE + 32'h40, 4'h0, 32'h0),
                     make_req(1'b0, BASE + 32'h80, 4'h0, 32'h0), gi, gd);
    end
    apply_stimulus(idle_req(), idle_req(), gi, gd);

    // Random traffic: requests held until acked, new ones raised at random.
    ci = idle_req();
    cd = idle_req();
    for (int c = 0; c < 400; c++) begin
      if (!ci.en && $urandom_range(0, 3) != 0) ci = rand_req();
      if (!cd.en && $urandom_range(0, 3) != 0) cd = rand_req();
      apply_stimulus(ci, cd, gi, gd);
      if (gi) ci = idle_req();
      if (gd) cd = idle_req();
    end
    apply_stimulus(idle_req(), idle_req(), gi, gd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/la132_sram_arbiter.md
# la132_sram_arbiter

Shares one single-port synchronous SRAM between the la132 core's instruction-SRAM and data-SRAM request ports. It round-robin arbitrates between the two requesters and issues at most one access per cycle. It returns read data and response status to the port that owned each access, one cycle after issue. It also range-checks addresses and answers out-of-window accesses with an error response without touching the SRAM.

## Interface
Parameters:
- ADDR_BASE, 32'h1C00_0000, byte base address of the SRAM window
- AW, 13, SRAM word-address width; window size is 4·2^AW bytes

Ports:
- clk  in  1  single clock, all state on rising edge
- hard_resetn  in  1  asynchronous, active-low reset
- inst_sram_en / data_sram_en  in  1  request valid, held until ack
- inst_sram_wr / data_sram_wr  in  1  1 = write, 0 = read
- inst_sram_strb / data_sram_strb  in  4  byte enables for writes
- inst_sram_fetch / data_sram_fetch  in  1  fetch attribute, forwarded to mem_fetch
- inst_sram_addr / data_sram_addr  in  32  byte address
- inst_sram_wdata / data_sram_wdata  in  32  write data
- inst_sram_ack / data_sram_ack  out  1  request accepted this cycle
- inst_sram_rrdy / data_sram_rrdy  out  1  completion pulse
- inst_sram_resp / data_sram_resp  out  1  valid with rrdy; 1 = address error
- inst_sram_rdata / data_sram_rdata  out  32  read data, valid with rrdy
- mem_en  out  1  SRAM access enable
- mem_wr  out  1  SRAM write
- mem_strb  out  4  SRAM byte write enables
- mem_fetch  out  1  attribute of the issued access
- mem_addr  out  AW  SRAM word address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

## Operation
- Issue is combinational in the request cycle.
- Arbitration:
  - If only one en is high, that port wins.
  - If both are high, the port not granted last wins.
  - last_grant register is updated on every grant; reset value = inst, so data wins the first tie.
- The winner gets ack=1 for exactly one cycle. The loser's ack=0, and it must hold its request.
- Range check: hit when (addr − ADDR_BASE) < 4·2^AW, computed as 32-bit unsigned subtraction; wrap-around below the base is a miss.
- Hit: mem_en=1, mem_wr/strb/fetch/wdata copied from the winner, mem_addr = (addr − ADDR_BASE)[AW+1:2]. addr[1:0] is ignored.
- Miss: mem_en=0. The access is still acked and completes with resp=1.
- When mem_en=0, all mem_* outputs drive 0.
- Response stage registers: rsp_valid, rsp_owner, rsp_err, rsp_wr.
  - The cycle after a grant, the owner's rrdy=1 and resp=rsp_err.
  - The owner's rdata = mem_rdata for a successful read, else 0.
- The non-owner's rrdy, resp and rdata are 0.
- Writes complete with rrdy as well, with rdata=0.
- Back-to-back issue is allowed every cycle. Responses return in issue order, one per cycle.
- Simultaneous grant and response: a new grant in cycle N+1 is independent of the response for the cycle-N grant.

## Timing
- Reset (hard_resetn low, asynchronous): rsp_valid=0, last_grant=inst. All ack/rrdy/resp/rdata outputs are 0 and all mem_* outputs are 0 while reset is low.
- Latency: ack in cycle N (same cycle as en if granted); rrdy in cycle N+1.
- Throughput: 1 access/cycle total. Under continuous contention each port gets 1 access per 2 cycles, so no starvation.
- Reset asserted mid-operation: any in-flight response is dropped, so no rrdy follows. Requesters must reissue after reset.
- Requests with en=0 are ignored regardless of the other request fields.

## Test plan
- Single read: inst read at addr 0x1C00_0010 with mem_rdata=0xDEAD_BEEF next cycle -> inst_sram_ack cycle 0, mem_addr=4, inst_sram_rrdy cycle 1 with rdata 0xDEAD_BEEF and resp 0. Data port outputs stay 0.
- Contention: both en held for 4 cycles from reset -> grant order data, inst, data, inst. Each rrdy pulses on the correct port one cycle after its ack.
- Write: data write to 0x1C00_0004 with strb 4'b0011 and wdata 0x1234_5678 -> mem_en=1, mem_wr=1, mem_addr=1, mem_strb=0011 in the ack cycle. data_sram_rrdy=1, resp=0, rdata=0 in the next cycle.
- Out of range: data read at 0x1BFF_FFFC and at 0x1C00_8000 (AW=13) -> ack, mem_en=0, then rrdy with resp=1 and rdata=0 for each.
- Back-to-back: inst reads at 0x1C00_0000, then 0x1C00_0004, then 0x1C00_0008 in consecutive cycles -> three acks on cycles 0-2 and three rrdy on cycles 1-3 carrying words 0, 1, 2.
- Reset mid-flight: assert hard_resetn low asynchronously in the cycle after an ack -> no rrdy. After release, both ties resolve to the data port first.
